// File: rtl/stage_sequencer_if.sv
// Sequencer <-> datapath bundle: start/halt, cache ready handshakes, decoded
// controller flags, stage enables, status and performance counters.
interface stage_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    // instrReady/dataReady are level-sensitive readies: the sequencer holds the
    // matching enable high and advances on the first rising edge that sees ready=1.
    logic                   start;
    logic                   haltRequest;
    logic                   instrReady;
    logic                   dataReady;
    logic                   memReadFlag;
    logic                   memWriteFlag;
    logic                   regWriteFlag;
    logic                   branchFlag;
    logic                   unconditionalBranchFlag;
    logic                   fetchEnable;
    logic                   decodeEnable;
    logic                   executeEnable;
    logic                   memEnable;
    logic                   writebackEnable;
    logic                   pcEnable;
    logic                   busy;
    logic                   faultFlag;
    logic [2:0]             stateCode;
    logic [COUNT_WIDTH-1:0] cycleCount;
    logic [COUNT_WIDTH-1:0] retireCount;

    modport master (
        input  start, haltRequest, instrReady, dataReady,
        input  memReadFlag, memWriteFlag, regWriteFlag, branchFlag, unconditionalBranchFlag,
        output fetchEnable, decodeEnable, executeEnable, memEnable, writebackEnable,
        output pcEnable, busy, faultFlag, stateCode, cycleCount, retireCount
    );

    modport slave (
        output start, haltRequest, instrReady, dataReady,
        output memReadFlag, memWriteFlag, regWriteFlag, branchFlag, unconditionalBranchFlag,
        input  fetchEnable, decodeEnable, executeEnable, memEnable, writebackEnable,
        input  pcEnable, busy, faultFlag, stateCode, cycleCount, retireCount
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with ready timeouts.
// Optional saturating perf counters: define STAGE_SEQUENCER_PERF_COUNTERS_EN.
module stage_sequencer #(
    parameter int MAX_WAIT    = 15,
    parameter int COUNT_WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    stage_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_retire_state;
    logic [7:0] r_wait;
    logic       r_mem_read;
    logic       r_mem_write;
    logic       r_reg_write;
    logic       r_branch;
    logic       r_uncond_branch;
    logic       r_fetch_en;
    logic       r_decode_en;
    logic       r_execute_en;
    logic       r_mem_en;
    logic       r_wb_en;
    logic       r_busy;
    logic       r_fault;
    logic       w_wait_expired;
    logic       w_mem_op;
    logic       w_pc_enable;
    logic       w_unused_branch_flags;

    assign w_wait_expired = (r_wait == 8'(MAX_WAIT - 1));
    assign w_mem_op       = r_mem_read | r_mem_write;
    assign w_retire_state = bus.haltRequest ? S_IDLE : S_FETCH;
    // Branch target selection happens inside the PC; the latched flags only document the path.
    assign w_unused_branch_flags = r_branch | r_uncond_branch;

    // A MEMORY retire depends on dataReady in the same cycle, so the PC pulse is
    // decoded combinationally; reset suppresses it so an aborted instruction never advances the PC.
    assign w_pc_enable = !reset && (
        (r_state == S_EXECUTE && !w_mem_op && !r_reg_write) ||
        (r_state == S_MEMORY && bus.dataReady && !(r_mem_read && r_reg_write)) ||
        (r_state == S_WRITEBACK));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (bus.start) w_next_state = S_FETCH;
            S_FETCH: begin
                if (bus.instrReady)      w_next_state = S_DECODE;
                else if (w_wait_expired) w_next_state = S_FAULT;
            end
            S_DECODE:    w_next_state = (bus.memReadFlag && bus.memWriteFlag) ? S_FAULT : S_EXECUTE;
            S_EXECUTE: begin
                if (w_mem_op)         w_next_state = S_MEMORY;
                else if (r_reg_write) w_next_state = S_WRITEBACK;
                else                  w_next_state = w_retire_state;
            end
            S_MEMORY: begin
                if (bus.dataReady)       w_next_state = (r_mem_read && r_reg_write) ? S_WRITEBACK : w_retire_state;
                else if (w_wait_expired) w_next_state = S_FAULT;
            end
            S_WRITEBACK: w_next_state = w_retire_state;
            S_FAULT:     w_next_state = S_FAULT;
            default:     w_next_state = S_FAULT;
        endcase
    end

    // Outputs are registered from the next state so they match the new state with no lag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wait          <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_reg_write     <= 1'b0;
            r_branch        <= 1'b0;
            r_uncond_branch <= 1'b0;
            r_fetch_en      <= 1'b0;
            r_decode_en     <= 1'b0;
            r_execute_en    <= 1'b0;
            r_mem_en        <= 1'b0;
            r_wb_en         <= 1'b0;
            r_busy          <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state)
                r_wait <= '0;
            else if (r_state == S_FETCH || r_state == S_MEMORY)
                r_wait <= r_wait + 8'd1;
            if (r_state == S_DECODE) begin
                r_mem_read      <= bus.memReadFlag;
                r_mem_write     <= bus.memWriteFlag;
                r_reg_write     <= bus.regWriteFlag;
                r_branch        <= bus.branchFlag;
                r_uncond_branch <= bus.unconditionalBranchFlag;
            end
            r_fetch_en   <= (w_next_state == S_FETCH);
            r_decode_en  <= (w_next_state == S_DECODE);
            r_execute_en <= (w_next_state == S_EXECUTE);
            r_mem_en     <= (w_next_state == S_MEMORY);
            r_wb_en      <= (w_next_state == S_WRITEBACK);
            r_busy       <= !(w_next_state == S_IDLE || w_next_state == S_FAULT);
            r_fault      <= (w_next_state == S_FAULT);
        end
    end

    assign bus.fetchEnable     = r_fetch_en;
    assign bus.decodeEnable    = r_decode_en;
    assign bus.executeEnable   = r_execute_en;
    assign bus.memEnable       = r_mem_en;
    assign bus.writebackEnable = r_wb_en;
    assign bus.pcEnable        = w_pc_enable;
    assign bus.busy            = r_busy;
    assign bus.faultFlag       = r_fault;
    assign bus.stateCode       = r_state;

`ifdef STAGE_SEQUENCER_PERF_COUNTERS_EN
    logic [COUNT_WIDTH-1:0] r_cycle_count;
    logic [COUNT_WIDTH-1:0] r_retire_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle_count  <= '0;
            r_retire_count <= '0;
        end else begin
            if (r_busy && r_cycle_count != '1)
                r_cycle_count <= r_cycle_count + COUNT_WIDTH'(1);
            if (w_pc_enable && r_retire_count != '1)
                r_retire_count <= r_retire_count + COUNT_WIDTH'(1);
        end
    end

    assign bus.cycleCount  = r_cycle_count;
    assign bus.retireCount = r_retire_count;
`else
    assign bus.cycleCount  = '0;
    assign bus.retireCount = '0;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: state walk, enables, retire pulses, faults, reset.
module tb_stage_sequencer;
    localparam int COUNT_WIDTH = 32;
`ifdef STAGE_SEQUENCER_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    stage_sequencer_if #(.COUNT_WIDTH(COUNT_WIDTH)) bus ();

    stage_sequencer #(.MAX_WAIT(15), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [COUNT_WIDTH-1:0] exp_cnt(input int v);
        return PERF ? COUNT_WIDTH'(v) : '0;
    endfunction

    // {fetch, decode, execute, mem, writeback, pc}
    function automatic logic [5:0] exp_en(input logic [2:0] st, input logic pc);
        logic [5:0] v;
        v = {st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4, st == 3'd5, pc};
        return v;
    endfunction

    function automatic logic [5:0] act_en();
        return {bus.fetchEnable, bus.decodeEnable, bus.executeEnable,
                bus.memEnable, bus.writebackEnable, bus.pcEnable};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ctrl(input logic mr, input logic mw, input logic rw, input logic br, input logic ub);
        bus.memReadFlag             = mr;
        bus.memWriteFlag            = mw;
        bus.regWriteFlag            = rw;
        bus.branchFlag              = br;
        bus.unconditionalBranchFlag = ub;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.haltRequest = 1'b0;
        bus.instrReady  = 1'b0;
        bus.dataReady   = 1'b0;
        set_ctrl(0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if (bus.stateCode !== 3'd0) $display("FAIL reset_state got %0d expected 0", bus.stateCode); else n_pass++;
        n_total++;
        if ({act_en(), bus.busy, bus.faultFlag} !== 8'b0)
            $display("FAIL reset_outputs got %b expected 00000000", {act_en(), bus.busy, bus.faultFlag}); else n_pass++;
        n_total++;
        if ({bus.cycleCount, bus.retireCount} !== '0)
            $display("FAIL reset_counters got %0d/%0d expected 0/0", bus.cycleCount, bus.retireCount); else n_pass++;
    endtask

    task automatic test_alu_op();
        logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        do_reset();
        set_ctrl(0, 0, 1, 0, 0);
        bus.instrReady = 1'b1; bus.dataReady = 1'b1; bus.haltRequest = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = 1'b0;
            #1;
            n_total++;
            if (bus.stateCode !== exp_st[i]) $display("FAIL alu_state[%0d] got %0d expected %0d", i, bus.stateCode, exp_st[i]); else n_pass++;
            n_total++;
            if (act_en() !== exp_en(exp_st[i], i == 3)) $display("FAIL alu_en[%0d] got %b expected %b", i, act_en(), exp_en(exp_st[i], i == 3)); else n_pass++;
        end
        tick();
        #1;
        n_total++;
        if ({bus.stateCode, bus.busy} !== 4'b0000) $display("FAIL alu_end_state got %0d busy %0b expected 0 busy 0", bus.stateCode, bus.busy); else n_pass++;
        n_total++;
        if (bus.retireCount !== exp_cnt(1)) $display("FAIL alu_retire got %0d expected %0d", bus.retireCount, exp_cnt(1)); else n_pass++;
        n_total++;
        if (bus.cycleCount !== exp_cnt(4)) $display("FAIL alu_cycles got %0d expected %0d", bus.cycleCount, exp_cnt(4)); else n_pass++;
    endtask

    task automatic test_load();
        logic [2:0] exp_st [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
        do_reset();
        set_ctrl(1, 0, 1, 0, 0);
        bus.instrReady = 1'b1; bus.haltRequest = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.start = 1'b0;
            bus.dataReady = (i == 6);
            #1;
            n_total++;
            if (bus.stateCode !== exp_st[i]) $display("FAIL load_state[%0d] got %0d expected %0d", i, bus.stateCode, exp_st[i]); else n_pass++;
            n_total++;
            if (act_en() !== exp_en(exp_st[i], i == 7)) $display("FAIL load_en[%0d] got %b expected %b", i, act_en(), exp_en(exp_st[i], i == 7)); else n_pass++;
        end
        tick();
        #1;
        n_total++;
        if (bus.stateCode !== 3'd0) $display("FAIL load_end_state got %0d expected 0", bus.stateCode); else n_pass++;
        n_total++;
        if (bus.cycleCount !== exp_cnt(8)) $display("FAIL load_cycles got %0d expected %0d", bus.cycleCount, exp_cnt(8)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_st [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3};
        do_reset();
        set_ctrl(0, 1, 0, 0, 0);
        bus.instrReady = 1'b1; bus.dataReady = 1'b1; bus.haltRequest = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.start = 1'b0;
            if (i == 4) begin
                set_ctrl(0, 0, 0, 1, 0);
                bus.haltRequest = 1'b1;
            end
            #1;
            n_total++;
            if (bus.stateCode !== exp_st[i]) $display("FAIL b2b_state[%0d] got %0d expected %0d", i, bus.stateCode, exp_st[i]); else n_pass++;
            n_total++;
            if (act_en() !== exp_en(exp_st[i], i == 3 || i == 6)) $display("FAIL b2b_en[%0d] got %b expected %b", i, act_en(), exp_en(exp_st[i], i == 3 || i == 6)); else n_pass++;
        end
        tick();
        #1;
        n_total++;
        if (bus.stateCode !== 3'd0) $display("FAIL b2b_end_state got %0d expected 0", bus.stateCode); else n_pass++;
        n_total++;
        if (bus.retireCount !== exp_cnt(2)) $display("FAIL b2b_retire got %0d expected %0d", bus.retireCount, exp_cnt(2)); else n_pass++;
        n_total++;
        if (bus.cycleCount !== exp_cnt(7)) $display("FAIL b2b_cycles got %0d expected %0d", bus.cycleCount, exp_cnt(7)); else n_pass++;
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        bus.start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            bus.start = 1'b0;
            #1;
            n_total++;
            if (bus.stateCode !== 3'd1) $display("FAIL timeout_fetch[%0d] got %0d expected 1", i, bus.stateCode); else n_pass++;
        end
        tick();
        #1;
        n_total++;
        if ({bus.stateCode, bus.faultFlag, bus.busy, act_en()} !== {3'd7, 1'b1, 1'b0, 6'b0})
            $display("FAIL timeout_fault got state %0d fault %0b busy %0b en %b expected 7 1 0 000000",
                     bus.stateCode, bus.faultFlag, bus.busy, act_en()); else n_pass++;
        n_total++;
        if (bus.cycleCount !== exp_cnt(15)) $display("FAIL timeout_cycles got %0d expected %0d", bus.cycleCount, exp_cnt(15)); else n_pass++;
        bus.start = 1'b1; bus.instrReady = 1'b1;
        tick();
        tick();
        #1;
        n_total++;
        if ({bus.stateCode, bus.faultFlag} !== {3'd7, 1'b1}) $display("FAIL fault_sticky got state %0d fault %0b expected 7 1", bus.stateCode, bus.faultFlag); else n_pass++;
        do_reset();
        #1;
        n_total++;
        if ({bus.stateCode, bus.faultFlag} !== {3'd0, 1'b0}) $display("FAIL fault_reset got state %0d fault %0b expected 0 0", bus.stateCode, bus.faultFlag); else n_pass++;
    endtask

    task automatic test_decode_fault();
        logic [2:0] exp_st [3] = '{3'd1, 3'd2, 3'd7};
        do_reset();
        set_ctrl(1, 1, 1, 0, 0);
        bus.instrReady = 1'b1; bus.dataReady = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.start = 1'b0;
            #1;
            n_total++;
            if (bus.stateCode !== exp_st[i]) $display("FAIL decfault_state[%0d] got %0d expected %0d", i, bus.stateCode, exp_st[i]); else n_pass++;
        end
        n_total++;
        if ({bus.faultFlag, bus.busy, act_en()} !== {1'b1, 1'b0, 6'b0})
            $display("FAIL decfault_outputs got fault %0b busy %0b en %b expected 1 0 000000", bus.faultFlag, bus.busy, act_en()); else n_pass++;
    endtask

    task automatic test_halt_mid();
        logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
        do_reset();
        set_ctrl(0, 0, 1, 0, 0);
        bus.instrReady = 1'b1; bus.dataReady = 1'b1; bus.haltRequest = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start = 1'b0;
            if (i == 2) bus.haltRequest = 1'b1;
            #1;
            n_total++;
            if (bus.stateCode !== exp_st[i]) $display("FAIL halt_state[%0d] got %0d expected %0d", i, bus.stateCode, exp_st[i]); else n_pass++;
            n_total++;
            if (act_en() !== exp_en(exp_st[i], i == 3)) $display("FAIL halt_en[%0d] got %b expected %b", i, act_en(), exp_en(exp_st[i], i == 3)); else n_pass++;
        end
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL halt_busy got %0b expected 0", bus.busy); else n_pass++;
        n_total++;
        if (bus.retireCount !== exp_cnt(1)) $display("FAIL halt_retire got %0d expected %0d", bus.retireCount, exp_cnt(1)); else n_pass++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        n_total++;
        if ({bus.stateCode, bus.busy} !== {3'd1, 1'b1}) $display("FAIL halt_relaunch got state %0d busy %0b expected 1 1", bus.stateCode, bus.busy); else n_pass++;
    endtask

    task automatic test_reset_mid_memory();
        logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        do_reset();
        set_ctrl(1, 0, 0, 0, 0);
        bus.instrReady = 1'b1; bus.dataReady = 1'b0; bus.haltRequest = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start = 1'b0;
            #1;
            n_total++;
            if (bus.stateCode !== exp_st[i]) $display("FAIL rstmem_state[%0d] got %0d expected %0d", i, bus.stateCode, exp_st[i]); else n_pass++;
        end
        bus.dataReady = 1'b1;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.pcEnable !== 1'b0) $display("FAIL rstmem_pc got %0b expected 0", bus.pcEnable); else n_pass++;
        tick();
        reset = 1'b0;
        bus.dataReady = 1'b0;
        #1;
        n_total++;
        if ({bus.stateCode, act_en(), bus.busy, bus.faultFlag} !== 11'b0)
            $display("FAIL rstmem_outputs got %b expected 00000000000", {bus.stateCode, act_en(), bus.busy, bus.faultFlag}); else n_pass++;
        n_total++;
        if ({bus.cycleCount, bus.retireCount} !== '0)
            $display("FAIL rstmem_counters got %0d/%0d expected 0/0", bus.cycleCount, bus.retireCount); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_back_to_back();
        test_fetch_timeout();
        test_decode_fault();
        test_halt_mid();
        test_reset_mid_memory();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
